sample_stream_distributor: RTL and testbench

Feeds the per-channel sample bus that the threshold integrator consumes. It takes packed 16-bit offset-binary samples from a 32-bit valid/ready stream and collects one complete 8-channel set in a shadow buffer. It commits each set to `value_out_concat` at a fixed update period, with one-cycle per-channel ready strobes, and raises `sample_core_done` once the first set is live. On `halt` (wired from the integrator's `over_threshold` and error flags) or on underflow, it forces every channel to midscale (zero current).

---
 rtl/sample_stream_pkg.sv | 17 +
 rtl/sample_shadow_buffer.sv | 64 ++++++
 rtl/sample_stream_distributor.sv | 181 ++++++++++++++++++
 tb/tb_sample_stream_distributor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_stream_pkg.sv
// Shared definitions for the sample stream distributor: FSM states and
// the fixed constants of the 8-channel / 4-word set format.
package sample_stream_pkg;

    localparam logic [15:0] MIDSCALE      = 16'h8000;
    localparam int          WORDS_PER_SET = 4;
    localparam int          MIN_PERIOD    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRIME   = 3'd1,
        ST_RUNNING = 3'd2,
        ST_HALTED  = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

endpackage

// File: rtl/sample_shadow_buffer.sv
// Shadow storage for one channel set (4 stream words) with a word count.
// set_next and full already include a write happening in the current cycle.
module sample_shadow_buffer
    import sample_stream_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            clear,
    input  logic                            wr_en,
    input  logic [WORD_W-1:0]               wr_data,
    output logic [2:0]                      count_next,
    output logic                            full,
    output logic [WORDS_PER_SET*WORD_W-1:0] set_next
);

    logic [WORDS_PER_SET-1:0][WORD_W-1:0] words_q;
    logic [WORDS_PER_SET-1:0][WORD_W-1:0] words_d;
    logic [WORDS_PER_SET-1:0][WORD_W-1:0] merged;
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic [2:0] count_inc;
    logic       wr_ok;

    assign wr_ok      = wr_en && (count_q < 3'(WORDS_PER_SET));
    assign count_inc  = count_q + {2'b00, wr_ok};
    assign full       = (count_inc == 3'(WORDS_PER_SET));
    assign count_next = clear ? 3'd0 : count_inc;
    assign set_next   = merged;

    // Storage view with the current-cycle write folded in.
    always_comb begin
        merged = words_q;
        if (wr_ok) begin
            merged[count_q[1:0]] = wr_data;
        end else begin
            merged = words_q;
        end
    end

    // Clear discards the count; stale words are never read once count is zero.
    always_comb begin
        words_d = merged;
        count_d = count_next;
        if (clear) begin
            words_d = words_q;
        end else begin
            words_d = merged;
        end
    end

    // Storage and count registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            words_q <= '0;
            count_q <= 3'd0;
        end else begin
            words_q <= words_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sample_stream_distributor.sv
// Collects 8-channel sample sets from a 32-bit stream and commits them to the
// channel bus at a fixed period; halts or underflows force midscale.
module sample_stream_distributor
    import sample_stream_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int SAMPLE_W = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic [31:0]                  update_period,
    input  logic [31:0]                  s_tdata,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic                         halt,
    output logic [CHANNELS*SAMPLE_W-1:0] value_out_concat,
    output logic [CHANNELS-1:0]          value_ready_concat,
    output logic                         sample_core_done,
    output logic                         err_underflow,
    output logic                         err_period,
    output logic                         halted
);

    localparam int                         OUT_W     = CHANNELS * SAMPLE_W;
    localparam logic [OUT_W-1:0]           MID_SET   = {CHANNELS{MIDSCALE}};
    localparam logic [CHANNELS-1:0]        ALL_READY = {CHANNELS{1'b1}};
    localparam logic [CHANNELS-1:0]        NO_READY  = {CHANNELS{1'b0}};

    state_e               state_q, state_d;
    logic [31:0]          period_q, period_d;
    logic [31:0]          timer_q, timer_d;
    logic [OUT_W-1:0]     value_q, value_d;
    logic [CHANNELS-1:0]  ready_q, ready_d;
    logic                 tready_q, tready_d;
    logic                 done_q, done_d;
    logic                 err_u_q, err_u_d;
    logic                 err_p_q, err_p_d;
    logic                 halted_q, halted_d;

    logic                 accept;
    logic                 buf_clear;
    logic [2:0]           buf_count_next;
    logic                 buf_full;
    logic [OUT_W-1:0]     buf_set;
    logic                 period_short;
    logic                 commit_point;

    assign accept       = s_tvalid && tready_q;
    assign period_short = (update_period < 32'(MIN_PERIOD));
    // PRIME commits as soon as the set completes; RUNNING only when the timer expires.
    assign commit_point = (state_q == ST_PRIME) ? buf_full : (timer_q == 32'd0);
    assign tready_d     = ((state_d == ST_PRIME) || (state_d == ST_RUNNING))
                          && (buf_count_next < 3'(WORDS_PER_SET));

    sample_shadow_buffer #(.WORD_W(32)) u_shadow (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (buf_clear),
        .wr_en      (accept),
        .wr_data    (s_tdata),
        .count_next (buf_count_next),
        .full       (buf_full),
        .set_next   (buf_set)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            period_q <= 32'd0;
            timer_q  <= 32'd0;
            value_q  <= MID_SET;
            ready_q  <= NO_READY;
            tready_q <= 1'b0;
            done_q   <= 1'b0;
            err_u_q  <= 1'b0;
            err_p_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            value_q  <= value_d;
            ready_q  <= ready_d;
            tready_q <= tready_d;
            done_q   <= done_d;
            err_u_q  <= err_u_d;
            err_p_q  <= err_p_d;
            halted_q <= halted_d;
        end
    end

    // Next-state decode; halt beats enable-drop beats underflow beats commit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = period_short ? ST_ERROR : ST_PRIME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME, ST_RUNNING: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else if (commit_point && !buf_full) begin
                    state_d = ST_ERROR;
                end else if (commit_point) begin
                    state_d = ST_RUNNING;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HALTED, ST_ERROR: state_d = state_q;
            default:             state_d = ST_IDLE;
        endcase
    end

    // Datapath, flags and timer for the current state.
    always_comb begin
        value_d   = value_q;
        ready_d   = NO_READY;
        done_d    = done_q;
        err_u_d   = err_u_q;
        err_p_d   = err_p_q;
        halted_d  = halted_q;
        timer_d   = timer_q;
        period_d  = period_q;
        buf_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                buf_clear = 1'b1;
                if (enable && period_short) begin
                    err_p_d = 1'b1;
                end else if (enable) begin
                    period_d = update_period;
                end else begin
                    period_d = period_q;
                end
            end
            ST_PRIME, ST_RUNNING: begin
                if (halt) begin
                    value_d  = MID_SET;
                    ready_d  = ALL_READY;
                    halted_d = 1'b1;
                end else if (!enable) begin
                    value_d   = MID_SET;
                    ready_d   = ALL_READY;
                    done_d    = 1'b0;
                    buf_clear = 1'b1;
                end else if (commit_point && buf_full) begin
                    value_d   = buf_set;
                    ready_d   = ALL_READY;
                    done_d    = 1'b1;
                    timer_d   = period_q - 32'd1;
                    buf_clear = 1'b1;
                end else if (commit_point) begin
                    value_d = MID_SET;
                    ready_d = ALL_READY;
                    err_u_d = 1'b1;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: value_d = value_q;
        endcase
    end

    assign s_tready           = tready_q;
    assign value_out_concat   = value_q;
    assign value_ready_concat = ready_q;
    assign sample_core_done   = done_q;
    assign err_underflow      = err_u_q;
    assign err_period         = err_p_q;
    assign halted             = halted_q;

endmodule

// File: tb/tb_sample_stream_distributor.sv
// Self-checking bench: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based behavioural model of the distributor.
module tb_sample_stream_distributor;

    localparam logic [127:0] MID_ALL = {8{16'h8000}};
    localparam int M_IDLE = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN = 2;
    localparam int M_STOP = 3;

    logic         clk = 1'b0;
    logic         resetn, enable, halt, s_tvalid;
    logic [31:0]  update_period, s_tdata;
    logic         s_tready, sample_core_done, err_underflow, err_period, halted;
    logic [127:0] value_out_concat;
    logic [7:0]   value_ready_concat;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0;

    // reference model state
    int           m_mode;
    int           m_per;
    int           next_commit;
    logic [31:0]  pend[$];
    logic [127:0] e_val;
    logic [7:0]   e_rdy;
    logic         e_trdy, e_done, e_eu, e_ep, e_h;

    sample_stream_distributor dut (
        .clk                (clk),
        .resetn             (resetn),
        .enable             (enable),
        .update_period      (update_period),
        .s_tdata            (s_tdata),
        .s_tvalid           (s_tvalid),
        .s_tready           (s_tready),
        .halt               (halt),
        .value_out_concat   (value_out_concat),
        .value_ready_concat (value_ready_concat),
        .sample_core_done   (sample_core_done),
        .err_underflow      (err_underflow),
        .err_period         (err_period),
        .halted             (halted)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Channel 2k is the low half of word k, channel 2k+1 the high half.
    function automatic logic [127:0] pack_set();
        logic [127:0] v;
        logic [31:0]  w;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            w = pend[i / 2];
            v[16*i +: 16] = (i % 2 == 0) ? w[15:0] : w[31:16];
        end
        return v;
    endfunction

    task automatic m_force();
        e_val = MID_ALL;
        e_rdy = 8'hFF;
    endtask

    task automatic model_step();
        if (!resetn) begin
            m_mode = M_IDLE;
            pend.delete();
            e_val = MID_ALL; e_rdy = 8'h00; e_trdy = 1'b0;
            e_done = 1'b0; e_eu = 1'b0; e_ep = 1'b0; e_h = 1'b0;
        end else begin
            if (s_tvalid && e_trdy) pend.push_back(s_tdata);
            e_rdy = 8'h00;
            case (m_mode)
                M_IDLE: begin
                    if (enable && update_period < 32'd8) begin
                        e_ep = 1'b1;
                        m_mode = M_STOP;
                    end else if (enable) begin
                        m_per = int'(update_period);
                        pend.delete();
                        m_mode = M_PRIME;
                    end
                end
                M_PRIME, M_RUN: begin
                    if (halt) begin
                        m_force(); e_h = 1'b1; m_mode = M_STOP;
                    end else if (!enable) begin
                        m_force(); e_done = 1'b0; pend.delete(); m_mode = M_IDLE;
                    end else if ((m_mode == M_PRIME && pend.size() == 4) ||
                                 (m_mode == M_RUN && cyc == next_commit)) begin
                        if (pend.size() == 4) begin
                            e_val = pack_set(); e_rdy = 8'hFF; e_done = 1'b1;
                            pend.delete();
                            next_commit = cyc + m_per;
                            m_mode = M_RUN;
                        end else begin
                            m_force(); e_eu = 1'b1; m_mode = M_STOP;
                        end
                    end
                end
                default: ;
            endcase
            e_trdy = (m_mode == M_PRIME || m_mode == M_RUN) && (pend.size() < 4);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            chk_eq("value",  value_out_concat, e_val);
            chk_eq("ready",  128'(value_ready_concat), 128'(e_rdy));
            chk_eq("tready", 128'(s_tready), 128'(e_trdy));
            chk_eq("done",   128'(sample_core_done), 128'(e_done));
            chk_eq("err_u",  128'(err_underflow), 128'(e_eu));
            chk_eq("err_p",  128'(err_period), 128'(e_ep));
            chk_eq("halted", 128'(halted), 128'(e_h));
        end
    end

    task automatic reset_dut();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = w;
        for (n = 0; n < 64 && !s_tready; n++) @(negedge clk);
        chk_eq("send_timeout", 128'(n < 64), 128'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic send_set(input logic [15:0] base);
        for (int k = 0; k < 4; k++) begin
            send_word({base + 16'(2*k + 1), base + 16'(2*k)});
        end
    endtask

    task automatic wait_commit();
        int n;
        for (n = 0; n < 64 && value_ready_concat !== 8'hFF; n++) @(negedge clk);
        chk_eq("commit_timeout", 128'(n < 64), 128'd1);
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; halt = 1'b0; s_tvalid = 1'b0;
        s_tdata = 32'd0; update_period = 32'd16;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("rst_value",  value_out_concat, MID_ALL);
        chk_eq("rst_ready",  128'(value_ready_concat), 128'd0);
        chk_eq("rst_tready", 128'(s_tready), 128'd0);
        chk_eq("rst_flags",  128'({sample_core_done, err_underflow, err_period, halted}), 128'd0);

        // normal run, period 16
        enable = 1'b1;
        @(negedge clk);
        send_set(16'h0000);
        chk_eq("first_set", value_out_concat, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        chk_eq("first_rdy", 128'(value_ready_concat), 128'hFF);
        chk_eq("first_done", 128'(sample_core_done), 128'd1);
        t0 = cyc;
        send_set(16'h0010);
        wait_commit();
        chk_eq("period16_gap", 128'(cyc - t0), 128'd16);
        chk_eq("second_set", value_out_concat, 128'h0017_0016_0015_0014_0013_0012_0011_0010);

        // underflow, period 8
        enable = 1'b0; reset_dut();
        update_period = 32'd8; enable = 1'b1;
        @(negedge clk);
        send_set(16'h0020);
        send_word(32'hAAAA_5555);
        send_word(32'h1234_5678);
        wait_commit();
        chk_eq("uf_flag",  128'(err_underflow), 128'd1);
        chk_eq("uf_value", value_out_concat, MID_ALL);
        repeat (3) @(negedge clk);
        chk_eq("uf_tready", 128'(s_tready), 128'd0);

        // period too short
        enable = 1'b0; reset_dut();
        update_period = 32'd7; enable = 1'b1;
        @(negedge clk);
        chk_eq("ep_flag", 128'(err_period), 128'd1);
        chk_eq("ep_done", 128'(sample_core_done), 128'd0);
        chk_eq("ep_rdy",  128'(value_ready_concat), 128'd0);

        // halt on the same cycle as a full-set commit point
        enable = 1'b0; reset_dut();
        update_period = 32'd8; enable = 1'b1;
        @(negedge clk);
        send_set(16'h0030);
        t0 = cyc;
        send_set(16'h0040);
        for (int n = 0; n < 50 && cyc < t0 + 7; n++) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk_eq("halt_flag",  128'(halted), 128'd1);
        chk_eq("halt_value", value_out_concat, MID_ALL);
        chk_eq("halt_rdy",   128'(value_ready_concat), 128'hFF);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk_eq("halt_quiet", 128'(value_ready_concat), 128'd0);
        end

        // reset mid-set while running
        enable = 1'b0; reset_dut();
        update_period = 32'd10; enable = 1'b1;
        @(negedge clk);
        send_set(16'h0050);
        send_word(32'h0101_0202);
        send_word(32'h0303_0404);
        resetn = 1'b0;
        @(negedge clk);
        chk_eq("mr_value", value_out_concat, MID_ALL);
        chk_eq("mr_done",  128'(sample_core_done), 128'd0);
        chk_eq("mr_tready", 128'(s_tready), 128'd0);
        resetn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) send_word(32'hC0DE_0000 + 32'(k));
        repeat (15) @(negedge clk);
        chk_eq("mr_no_commit", 128'(sample_core_done), 128'd0);
        send_word(32'hC0DE_0003);
        chk_eq("mr_commit", value_out_concat, 128'hC0DE_0003_C0DE_0002_C0DE_0001_C0DE_0000);

        // randomized traffic
        for (int ep = 0; ep < 12; ep++) begin
            enable = 1'b0; halt = 1'b0; s_tvalid = 1'b0;
            reset_dut();
            update_period = 32'($urandom_range(6, 20));
            enable = 1'b1;
            for (int c = 0; c < 250; c++) begin
                @(negedge clk);
                s_tvalid = ($urandom_range(0, 3) < (ep % 4) + 1);
                s_tdata  = $urandom;
                halt     = ($urandom_range(0, 299) == 0);
                enable   = ($urandom_range(0, 149) != 0);
                resetn   = ($urandom_range(0, 399) != 0);
            end
        end
        resetn = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
